bcd_to_decimal: RTL and testbench
=================================

BCD_TO_DECIMAL -- requirements
Module: bcd_to_decimal

Interface
REQ-001 Parameter TIMEOUT, default 0: cycles a held output may wait for out_ack before being dropped; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 Din  input  4  BCD code to decode, 0..9 legal, 10..15 illegal.
REQ-005 in_valid  input  1  Din is presented this cycle.
REQ-006 in_ready  output  1  the block accepts Din this cycle.
REQ-007 Dout  output  10  registered one-hot decimal digit; bit k set means digit k.
REQ-008 out_valid  output  1  Dout/ERR hold a decoded result; the reverse of the encoder's CHK.
REQ-009 out_ack  input  1  consumer takes the current result.
REQ-010 ERR  output  1  the held result came from an illegal code.
REQ-011 TO  output  1  one-cycle pulse: a held result was dropped by timeout.
REQ-012 err_cnt  output  4  count of accepted illegal codes, saturating.

Function
REQ-013 FSM states SHALL be EMPTY (no result held) and FULL (result held); out_valid = (state == FULL).
REQ-014 in_ready SHALL be combinational: 1 in EMPTY; in FULL, equal to out_ack.
REQ-015 Transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-016 On transfer, Dout SHALL load the decode of Din and the state SHALL become FULL. Latency: result visible exactly 1 cycle after the accepting edge.
REQ-017 Legal Din = k (0..9) SHALL give Dout = 1<<k and ERR = 0.
REQ-018 Illegal Din (10..15) SHALL give Dout = 0 and ERR = 1, and SHALL increment err_cnt.
REQ-019 err_cnt SHALL saturate at 15 and never wrap.
REQ-020 In FULL with out_ack=1 and an accepted input in the same cycle, the new result SHALL replace the old one. The state stays FULL; there are no bubbles (back-to-back rate of 1 per cycle).
REQ-021 In FULL with out_ack=1 and no transfer, the state SHALL go to EMPTY and Dout/ERR SHALL clear to 0.
REQ-022 In FULL with out_ack=0, Dout/ERR SHALL be held stable, and Din SHALL be ignored.
REQ-023 Wait counter:
- Clears on each load.
- Increments each FULL cycle without out_ack.
- When TIMEOUT>0 and the counter reaches TIMEOUT-1 with out_ack=0, the next edge SHALL go to EMPTY, clear Dout/ERR, and pulse TO for exactly 1 cycle.
REQ-024 An out_ack arriving in the same cycle as the timeout condition SHALL win: normal hand-off, no TO pulse.
REQ-025 In the TO-pulse cycle the state is EMPTY, so in_ready = 1.
REQ-026 Wait counter width: $clog2(TIMEOUT+1), minimum 1 bit.
REQ-027 out_ack while EMPTY SHALL have no effect.

Reset
REQ-028 On a rising edge with rst_n=0, the block SHALL enter EMPTY and clear Dout, ERR, TO, err_cnt and the wait counter to 0.
REQ-029 During reset, in_ready SHALL read 1 (state EMPTY) but no transfer SHALL occur.
REQ-030 Reset asserted mid-hold SHALL discard the held result without a TO pulse.

Structure
REQ-031 The shared package SHALL hold:
- the state enum (EMPTY, FULL);
- constant BCD_W = 4;
- constant DIGITS = 10;
- constant ERR_CNT_MAX = 15.
REQ-032 The combinational code-to-one-hot-plus-illegal-flag function SHALL be a sub-module bcd_onehot_dec (Din[3:0] -> onehot[9:0], illegal). The sequential wrapper instantiates it once.

Verification
REQ-033 Reset, then Din=7 with in_valid=1, out_ack=0 -> next cycle Dout=0x080, out_valid=1, ERR=0; Dout held for 5 cycles while in_ready=0.
REQ-034 Stream Din=0..9 back-to-back with out_ack=1 throughout -> Dout=0x001,0x002,...,0x200 on 10 consecutive cycles, in_ready stays 1.
REQ-035 Send Din=12 -> Dout=0, ERR=1, err_cnt=1. Then send 20 illegal codes -> err_cnt stays at 15.
REQ-036 TIMEOUT=4, Din=3 accepted, no ack -> out_valid high 4 cycles, then EMPTY with TO=1 for one cycle. Repeat with out_ack on cycle 4 -> no TO.
REQ-037 Din=5 held with out_ack=0, rst_n=0 for one edge -> out_valid=0, Dout=0, err_cnt=0, TO=0.
REQ-038 out_ack=1 while EMPTY with in_valid=0 -> out_valid stays 0, no state change.

Source files
------------

// File: rtl/bcd_to_decimal_pkg.sv
// rtl/bcd_to_decimal_pkg.sv - shared types and constants for the BCD-to-decimal decoder
package bcd_to_decimal_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int          BCD_W       = 4;
    localparam int          DIGITS      = 10;
    localparam logic [3:0]  ERR_CNT_MAX = 4'd15;

endpackage

// File: rtl/bcd_onehot_dec.sv
// rtl/bcd_onehot_dec.sv - combinational BCD code to one-hot digit plus illegal flag
module bcd_onehot_dec
    import bcd_to_decimal_pkg::*;
(
    input  logic [BCD_W-1:0]  Din,
    output logic [DIGITS-1:0] onehot,
    output logic              illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        if (Din < BCD_W'(DIGITS)) begin
            onehot = {{(DIGITS-1){1'b0}}, 1'b1} << Din;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_to_decimal.sv
// rtl/bcd_to_decimal.sv - registered BCD decoder with one-entry output hold, ack handshake and hold timeout
module bcd_to_decimal
    import bcd_to_decimal_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BCD_W-1:0]  Din,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DIGITS-1:0] Dout,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              ERR,
    output logic              TO,
    output logic [3:0]        err_cnt
);

    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = (TIMEOUT > 0) ? WCNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic [DIGITS-1:0]   dout_q, dout_d;
    logic                err_q, err_d;
    logic                to_q, to_d;
    logic [3:0]          err_cnt_q, err_cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [DIGITS-1:0]   dec_onehot;
    logic                dec_illegal;
    logic                xfer;
    logic                timeout_hit;

    bcd_onehot_dec u_dec (
        .Din     (Din),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    // A held result frees the slot in the same cycle it is acked, so ack doubles as ready.
    assign in_ready    = (state_q == EMPTY) || out_ack;
    assign xfer        = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT > 0) && (state_q == FULL) && !out_ack && (wcnt_q == WCNT_LAST);

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        err_d     = err_q;
        to_d      = 1'b0;
        err_cnt_d = err_cnt_q;
        wcnt_d    = wcnt_q;

        if (xfer) begin
            state_d = FULL;
            dout_d  = dec_onehot;
            err_d   = dec_illegal;
            wcnt_d  = '0;
            if (dec_illegal && (err_cnt_q != ERR_CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 4'd1;
            end
        end else if (state_q == FULL) begin
            if (out_ack) begin
                state_d = EMPTY;
                dout_d  = '0;
                err_d   = 1'b0;
            end else if (timeout_hit) begin
                state_d = EMPTY;
                dout_d  = '0;
                err_d   = 1'b0;
                to_d    = 1'b1;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            dout_q    <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            err_cnt_q <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            to_q      <= to_d;
            err_cnt_q <= err_cnt_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign Dout      = dout_q;
    assign ERR       = err_q;
    assign TO        = to_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bcd_to_decimal.sv
// tb/tb_bcd_to_decimal.sv - self-checking bench for bcd_to_decimal (default and TIMEOUT=4 instances)
module tb_bcd_to_decimal;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ack;
    logic [3:0] din;

    logic       in_ready0, out_valid0, err0, to0;
    logic [9:0] dout0;
    logic [3:0] err_cnt0;
    logic       in_ready4, out_valid4, err4, to4;
    logic [9:0] dout4;
    logic [3:0] err_cnt4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] din;
        logic [9:0] dout;
        logic       err;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [9:0] dout;
        logic       err;
    } res_t;

    vec_t tbl[16];
    res_t exp_q[$];
    res_t sb_e;
    int   sat_exp;

    always #5 clk = ~clk;

    bcd_to_decimal dut0 (
        .clk(clk), .rst_n(rst_n), .Din(din), .in_valid(in_valid), .in_ready(in_ready0),
        .Dout(dout0), .out_valid(out_valid0), .out_ack(out_ack), .ERR(err0), .TO(to0),
        .err_cnt(err_cnt0)
    );

    bcd_to_decimal #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Din(din), .in_valid(in_valid), .in_ready(in_ready4),
        .Dout(dout4), .out_valid(out_valid4), .out_ack(out_ack), .ERR(err4), .TO(to4),
        .err_cnt(err_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t expect_of(input logic [3:0] d);
        res_t r;
        r.dout = (d <= 4'd9) ? (10'd1 << d) : 10'd0;
        r.err  = (d > 4'd9);
        return r;
    endfunction

    // Scoreboard on the untimed instance: push on accept, pop on hand-off.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid0 && out_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: result 0x%0h handed off with no expected entry", dout0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_dout", 32'(dout0), 32'(sb_e.dout));
                    check("sb_err", 32'(err0), 32'(sb_e.err));
                end
            end
            if (in_valid && in_ready0) begin
                exp_q.push_back(expect_of(din));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd0,  10'h001, 1'b0, 4'd0};
        tbl[1]  = '{4'd1,  10'h002, 1'b0, 4'd0};
        tbl[2]  = '{4'd2,  10'h004, 1'b0, 4'd0};
        tbl[3]  = '{4'd3,  10'h008, 1'b0, 4'd0};
        tbl[4]  = '{4'd4,  10'h010, 1'b0, 4'd0};
        tbl[5]  = '{4'd5,  10'h020, 1'b0, 4'd0};
        tbl[6]  = '{4'd6,  10'h040, 1'b0, 4'd0};
        tbl[7]  = '{4'd7,  10'h080, 1'b0, 4'd0};
        tbl[8]  = '{4'd8,  10'h100, 1'b0, 4'd0};
        tbl[9]  = '{4'd9,  10'h200, 1'b0, 4'd0};
        tbl[10] = '{4'd12, 10'h000, 1'b1, 4'd1};
        tbl[11] = '{4'd10, 10'h000, 1'b1, 4'd2};
        tbl[12] = '{4'd11, 10'h000, 1'b1, 4'd3};
        tbl[13] = '{4'd13, 10'h000, 1'b1, 4'd4};
        tbl[14] = '{4'd14, 10'h000, 1'b1, 4'd5};
        tbl[15] = '{4'd15, 10'h000, 1'b1, 4'd6};

        rst_n = 1'b0; in_valid = 1'b0; out_ack = 1'b0; din = 4'd0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1; din = 4'd3;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_to", 32'(to0), 32'd0);
        check("rst_err_cnt", 32'(err_cnt0), 32'd0);
        check("rst_out_valid4", 32'(out_valid4), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);

        // Hold with no ack; a second code offered meanwhile must be ignored.
        din = 4'd7; in_valid = 1'b1; out_ack = 1'b0;
        @(negedge clk);
        check("hold_first_valid", 32'(out_valid0), 32'd1);
        check("hold_first_dout", 32'(dout0), 32'h080);
        check("hold_first_err", 32'(err0), 32'd0);
        din = 4'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_dout", 32'(dout0), 32'h080);
            check("hold_in_ready", 32'(in_ready0), 32'd0);
            check("hold_valid", 32'(out_valid0), 32'd1);
        end
        in_valid = 1'b0; out_ack = 1'b1;
        @(negedge clk);
        check("drain_valid", 32'(out_valid0), 32'd0);
        check("drain_dout", 32'(dout0), 32'd0);
        @(negedge clk);
        check("idle_ack_valid", 32'(out_valid0), 32'd0);
        check("idle_ack_ready", 32'(in_ready0), 32'd1);

        // Back-to-back stream over every code with ack held high.
        for (int i = 0; i < 16; i++) begin
            din = tbl[i].din; in_valid = 1'b1;
            @(negedge clk);
            check("tbl_dout", 32'(dout0), 32'(tbl[i].dout));
            check("tbl_err", 32'(err0), 32'(tbl[i].err));
            check("tbl_valid", 32'(out_valid0), 32'd1);
            check("tbl_in_ready", 32'(in_ready0), 32'd1);
            check("tbl_err_cnt", 32'(err_cnt0), 32'(tbl[i].cnt));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_end_valid", 32'(out_valid0), 32'd0);

        for (int i = 0; i < 20; i++) begin
            din = 4'(10 + (i % 6)); in_valid = 1'b1;
            @(negedge clk);
            sat_exp = (7 + i > 15) ? 15 : 7 + i;
            check("sat_err_cnt", 32'(err_cnt0), 32'(sat_exp));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a hold.
        out_ack = 1'b0; din = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        check("midrst_pre_dout", 32'(dout0), 32'h020);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid0), 32'd0);
        check("midrst_dout", 32'(dout0), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt0), 32'd0);
        check("midrst_to", 32'(to0), 32'd0);
        check("midrst_to4", 32'(to4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Timeout expiry on the TIMEOUT=4 instance.
        din = 4'd3; in_valid = 1'b1; out_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("to_hold_valid4", 32'(out_valid4), 32'd1);
            check("to_hold_dout4", 32'(dout4), 32'h008);
            check("to_hold_to4", 32'(to4), 32'd0);
        end
        @(negedge clk);
        check("to_fire_valid4", 32'(out_valid4), 32'd0);
        check("to_fire_to4", 32'(to4), 32'd1);
        check("to_fire_dout4", 32'(dout4), 32'd0);
        check("to_fire_ready4", 32'(in_ready4), 32'd1);
        check("to_untimed_holds", 32'(out_valid0), 32'd1);
        din = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        check("to_pulse_end", 32'(to4), 32'd0);
        check("to_reload_valid4", 32'(out_valid4), 32'd1);
        check("to_reload_dout4", 32'(dout4), 32'h200);
        in_valid = 1'b0; out_ack = 1'b1;
        @(negedge clk);
        check("to_clear_valid0", 32'(out_valid0), 32'd0);
        check("to_clear_valid4", 32'(out_valid4), 32'd0);
        out_ack = 1'b0;

        // Ack in the last cycle before expiry wins over the timeout.
        din = 4'd3; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("ack_win_hold4", 32'(out_valid4), 32'd1);
            check("ack_win_to4", 32'(to4), 32'd0);
        end
        out_ack = 1'b1;
        @(negedge clk);
        check("ack_win_valid4", 32'(out_valid4), 32'd0);
        check("ack_win_no_to4", 32'(to4), 32'd0);
        out_ack = 1'b0;
        @(negedge clk);
        check("ack_win_no_to4_late", 32'(to4), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
